uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single byte-wide UART TX stream between two producers:
//  - the ECHO pass-through path of the command FSM;
//  - the ALU result path.
//  Arbitrates only at packet boundaries, so TX frames are never interleaved.
//  Frames each ALU result into a response packet, then serializes it.
//  Sits between the command FSM/ALU and the UART transmitter.
// PARAMETERS
//  RES_BYTES_MAX_P  8  max ALU result payload bytes; res_data_i width = 8*RES_BYTES_MAX_P
// PORTS
//  clk            in   1   single clock, all logic posedge
//  rst_n          in   1   synchronous, active-low reset
//  echo_data_i    in   8   echo byte, already framed upstream
//  echo_valid_i   in   1   echo byte valid
//  echo_last_i    in   1   qualifies final byte of an echo packet
//  echo_ready_o   out  1   echo byte accepted when valid&ready
//  res_data_i     in   64  ALU result; bytes sent LSB-first
//  res_len_i      in   4   payload byte count, 0..8; >8 treated as 8
//  res_opcode_i   in   8   opcode echoed in the response header
//  res_valid_i    in   1   result available
//  res_ready_o    out  1   result captured when valid&ready
//  tx_data_o      out  8   byte to UART TX
//  tx_valid_o     out  1   byte valid
//  tx_ready_i     in   1   UART TX can take a byte
//  busy_o         out  1   high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge) forces:
//  - state=IDLE, rr_q=0 (result favored first), all shift/count regs 0.
//  - echo_ready_o, res_ready_o, tx_valid_o, busy_o = 0; tx_data_o = 0.
//  States: IDLE, ECHO, RES_SEND. The state enum lives in the shared package.
//  IDLE:
//  - Sample requests echo_valid_i and res_valid_i.
//  - Only one valid -> grant it.
//  - Both valid -> grant the side not served last (rr_q).
//  - Grant result -> res_ready_o=1 this cycle (combinational). The frame is loaded and the state goes to RES_SEND. Set rr_q=1.
//  - Grant echo -> go to ECHO. No byte moves in the grant cycle. Set rr_q=0.
//  ECHO (zero-latency pass-through):
//  - tx_data_o=echo_data_i, tx_valid_o=echo_valid_i, echo_ready_o=tx_ready_i.
//  - A handshake with echo_last_i=1 returns to IDLE next cycle.
//  - Result requests wait; the result path is never preempted mid-packet.
//  RES_SEND:
//  - Frame = {opcode, 8'h00, LEN[7:0], LEN[15:8], payload[0..n-1]}.
//  - LEN = 4+n: total bytes including the 4-byte header, the same convention as the inbound command protocol.
//  - tx_data_o and tx_valid_o are registered. First header byte is valid the cycle after capture.
//  - Each tx_valid_o&tx_ready_i advances the shift register one byte and increments the byte counter.
//  - After byte 4+n-1 is accepted -> IDLE. tx_valid_o drops the same edge.
//  - tx_ready_i low -> tx_data_o and tx_valid_o hold stable; valid is never retracted.
//  - res_ready_o=0 here. echo_ready_o=0 outside ECHO.
//  Boundaries:
//  - n=0 -> header-only frame, LEN=4.
//  - n>8 -> clamp to 8, LEN=12.
//  - Back-to-back results with echo idle: re-arbitrated through IDLE, one bubble cycle allowed.
//  - res_data_i and res_opcode_i are sampled only at capture; later input changes are ignored.
//  - Reset mid-packet -> partial frame dropped, outputs go to reset values next cycle.
//    The UART sees a truncated frame; recovery is host-side.
//  Width/arithmetic:
//  - LEN computed in 16 bits, so the MSB byte is always 0 for legal n.
//  - Byte counter is 4 bits, range 0..11; it cannot wrap for legal n.
// STRUCTURE
//  config_pkg additions:
//  - tx_arb_state_t {IDLE, ECHO, RES_SEND}
//  - RESP_HDR_BYTES=4
//  - RESP_RSVD_BYTE=8'h00
//  Sub-module tx_frame_serializer:
//  - 12-byte load-parallel, shift-out-byte register with count, ready/valid output.
//  Arbiter FSM and rr_q stay in uart_tx_arbiter.
// TESTING
//  1 Result only: res_valid, opcode=8'h01, len=4, data=32'hDDCCBBAA, tx_ready=1
//    -> tx bytes 01,00,08,00,AA,BB,CC,DD on 8 consecutive cycles, then busy_o=0.
//  2 Echo only: 3 bytes 11,22,33, last on 33
//    -> appear on tx_data_o the same cycle as presented; state returns to IDLE.
//  3 Both valid in IDLE after reset -> result frame sent first, then echo.
//    Repeat with both valid again -> echo wins (round-robin).
//  4 Backpressure: tx_ready_i toggled 1,0,0,1 during a result frame
//    -> tx_data_o stable while low; no byte dropped or duplicated.
//  5 len=0, opcode=8'h02 -> exactly 02,00,04,00. len=15 -> LEN byte 0C, 8 payload bytes.
//  6 rst_n low for one cycle after 2 bytes of a result frame
//    -> tx_valid_o=0 next cycle; a subsequent echo passes cleanly.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART TX arbiter and its response framer.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StEcho,
        StResSend
    } tx_arb_state_t;

    localparam int unsigned RESP_HDR_BYTES = 4;
    localparam logic [7:0]  RESP_RSVD_BYTE = 8'h00;
    localparam int unsigned RES_BYTES_MAX  = 8;

    // LEN counts the header too, matching the inbound command protocol.
    function automatic logic [15:0] resp_total_len(input logic [3:0] n);
        return 16'(RESP_HDR_BYTES) + 16'(n);
    endfunction

endpackage

// File: rtl/tx_frame_serializer.sv
// Parallel-load frame register that shifts one byte out per ready/valid handshake, LSB byte first.
module tx_frame_serializer #(
    parameter int unsigned NumBytes = 12
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    load_i,
    input  logic [8*NumBytes-1:0]   frame_i,
    input  logic [3:0]              len_i,
    output logic [7:0]              tx_data_o,
    output logic                    tx_valid_o,
    input  logic                    tx_ready_i,
    output logic                    done_o
);

    logic [8*NumBytes-1:0] shift_q, shift_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [3:0]            len_q, len_d;
    logic                  valid_q, valid_d;
    logic                  fire;
    logic                  last;

    assign fire   = valid_q && tx_ready_i;
    assign last   = (cnt_q == len_q - 4'd1);
    assign done_o = fire && last;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        valid_d = valid_q;
        if (load_i) begin
            shift_d = frame_i;
            cnt_d   = 4'd0;
            len_d   = len_i;
            valid_d = 1'b1;
        end else if (fire) begin
            shift_d = {8'h00, shift_q[8*NumBytes-1:8]};
            cnt_d   = cnt_q + 4'd1;
            if (last) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shift_q <= '0;
            cnt_q   <= 4'd0;
            len_q   <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            valid_q <= valid_d;
        end
    end

    assign tx_data_o  = shift_q[7:0];
    assign tx_valid_o = valid_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART TX byte stream between the echo path and framed ALU results,
// switching owners only at packet boundaries.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned RES_BYTES_MAX_P = RES_BYTES_MAX
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   echo_data_i,
    input  logic                         echo_valid_i,
    input  logic                         echo_last_i,
    output logic                         echo_ready_o,
    input  logic [8*RES_BYTES_MAX_P-1:0] res_data_i,
    input  logic [3:0]                   res_len_i,
    input  logic [7:0]                   res_opcode_i,
    input  logic                         res_valid_i,
    output logic                         res_ready_o,
    output logic [7:0]                   tx_data_o,
    output logic                         tx_valid_o,
    input  logic                         tx_ready_i,
    output logic                         busy_o
);

    localparam int unsigned FrameBytes = RESP_HDR_BYTES + RES_BYTES_MAX_P;

    tx_arb_state_t state_q, state_d;
    logic          rr_q, rr_d;
    logic          load;
    logic          ser_done;
    logic [7:0]    ser_data;
    logic          ser_valid;

    logic [3:0]              n_eff;
    logic [15:0]             len_total;
    logic [8*FrameBytes-1:0] frame;

    // Unused payload bytes are zeroed so the shifter drains back to 0.
    always_comb begin
        n_eff     = (res_len_i > 4'(RES_BYTES_MAX_P)) ? 4'(RES_BYTES_MAX_P) : res_len_i;
        len_total = resp_total_len(n_eff);
        frame     = '0;
        frame[7:0]   = res_opcode_i;
        frame[15:8]  = RESP_RSVD_BYTE;
        frame[23:16] = len_total[7:0];
        frame[31:24] = len_total[15:8];
        for (int unsigned i = 0; i < RES_BYTES_MAX_P; i++) begin
            if (i < 32'(n_eff)) begin
                frame[8*(RESP_HDR_BYTES+i) +: 8] = res_data_i[8*i +: 8];
            end
        end
    end

    tx_frame_serializer #(
        .NumBytes (FrameBytes)
    ) u_ser (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (load),
        .frame_i    (frame),
        .len_i      (len_total[3:0]),
        .tx_data_o  (ser_data),
        .tx_valid_o (ser_valid),
        .tx_ready_i (tx_ready_i),
        .done_o     (ser_done)
    );

    // rr_q=1 means the result was served last, so echo wins a tie.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        res_ready_o  = 1'b0;
        echo_ready_o = 1'b0;
        load         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (res_valid_i && (!echo_valid_i || !rr_q)) begin
                    res_ready_o = 1'b1;
                    load        = 1'b1;
                    state_d     = StResSend;
                    rr_d        = 1'b1;
                end else if (echo_valid_i) begin
                    state_d = StEcho;
                    rr_d    = 1'b0;
                end
            end
            StEcho: begin
                echo_ready_o = tx_ready_i;
                if (echo_valid_i && tx_ready_i && echo_last_i) begin
                    state_d = StIdle;
                end
            end
            StResSend: begin
                if (ser_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        tx_data_o  = ser_data;
        tx_valid_o = ser_valid;
        if (state_q == StEcho) begin
            tx_data_o  = echo_data_i;
            tx_valid_o = echo_valid_i;
        end
    end

    assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: directed frame table, arbitration/backpressure/reset sequences,
// and randomized traffic checked against a byte-queue model of the response framing.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  echo_data_i = '0;
    logic        echo_valid_i = 1'b0;
    logic        echo_last_i = 1'b0;
    logic        echo_ready_o;
    logic [63:0] res_data_i = '0;
    logic [3:0]  res_len_i = '0;
    logic [7:0]  res_opcode_i = '0;
    logic        res_valid_i = 1'b0;
    logic        res_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic        busy_o;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .RES_BYTES_MAX_P (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .echo_data_i  (echo_data_i),
        .echo_valid_i (echo_valid_i),
        .echo_last_i  (echo_last_i),
        .echo_ready_o (echo_ready_o),
        .res_data_i   (res_data_i),
        .res_len_i    (res_len_i),
        .res_opcode_i (res_opcode_i),
        .res_valid_i  (res_valid_i),
        .res_ready_o  (res_ready_o),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i),
        .busy_o       (busy_o)
    );

    typedef struct {
        logic [7:0]  op;
        logic [3:0]  len;
        logic [63:0] data;
        logic [95:0] exp_bytes;
        int          exp_n;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference framing: opcode, reserved, 16-bit total length LSB first, clamped payload.
    function automatic void model_frame(input logic [7:0] op, input logic [3:0] len,
                                        input logic [63:0] data);
        int          n;
        logic [15:0] total;
        n     = (int'(len) > 8) ? 8 : int'(len);
        total = 16'(4 + n);
        exp_q.push_back(op);
        exp_q.push_back(8'h00);
        exp_q.push_back(total[7:0]);
        exp_q.push_back(total[15:8]);
        for (int i = 0; i < n; i++) exp_q.push_back(data[8*i +: 8]);
    endfunction

    task automatic start_result(input logic [7:0] op, input logic [3:0] len,
                                input logic [63:0] data, input bit keep);
        res_opcode_i = op;
        res_len_i    = len;
        res_data_i   = data;
        res_valid_i  = 1'b1;
        @(negedge clk);
        chk("res_grant", 64'({res_ready_o, echo_ready_o, busy_o}), 64'(3'b100));
        @(posedge clk); #1;
        res_valid_i = keep;
        if (!keep) begin
            res_opcode_i = 8'($urandom);
            res_data_i   = {$urandom, $urandom};
            res_len_i    = 4'($urandom);
        end
    endtask

    task automatic drain(input int pct, input logic [15:0] pat, input bit use_pat,
                         output int cycles);
        logic       held;
        logic [7:0] held_data;
        logic [7:0] e;
        held      = 1'b0;
        held_data = '0;
        cycles    = 0;
        while (exp_q.size() > 0 && cycles < 300) begin
            if (use_pat) tx_ready_i = (cycles < 16) ? pat[cycles] : 1'b1;
            else         tx_ready_i = (int'($urandom_range(99)) < pct);
            @(negedge clk);
            if (held) chk("hold_stable", 64'({tx_valid_o, tx_data_o}), 64'({1'b1, held_data}));
            if (tx_valid_o && tx_ready_i) begin
                e = exp_q.pop_front();
                chk("tx_byte", 64'(tx_data_o), 64'(e));
                held = 1'b0;
            end else begin
                held      = tx_valid_o;
                held_data = tx_data_o;
            end
            cycles++;
            @(posedge clk); #1;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", 64'(exp_q.size()), 64'(0));
            exp_q.delete();
        end
    endtask

    task automatic echo_packet(input logic [31:0] b, input int n, input int pct);
        int   tries;
        logic done;
        echo_valid_i = 1'b1;
        echo_data_i  = b[7:0];
        echo_last_i  = (n == 1);
        @(negedge clk);
        chk("echo_grant", 64'({echo_ready_o, res_ready_o, tx_valid_o}), 64'(3'b000));
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            tries = 0;
            done  = 1'b0;
            echo_data_i = b[8*k +: 8];
            echo_last_i = (k == n - 1);
            while (!done) begin
                tx_ready_i = (tries >= 50) || (int'($urandom_range(99)) < pct);
                @(negedge clk);
                chk("echo_pass", 64'({tx_valid_o, tx_data_o, echo_ready_o}),
                    64'({1'b1, b[8*k +: 8], tx_ready_i}));
                done = tx_ready_i;
                tries++;
                @(posedge clk); #1;
            end
        end
        echo_valid_i = 1'b0;
        echo_last_i  = 1'b0;
    endtask

    task automatic check_idle();
        @(negedge clk);
        chk("idle", 64'({busy_o, tx_valid_o}), 64'(2'b00));
        @(posedge clk); #1;
    endtask

    initial begin
        int          cyc;
        logic [7:0]  r_op;
        logic [3:0]  r_len;
        logic [63:0] r_data;
        logic [31:0] r_echo;

        vecs[0] = '{8'h01, 4'd4,  64'h00000000_DDCCBBAA, 96'h0000_0000_DDCC_BBAA_0008_0001, 8};
        vecs[1] = '{8'h02, 4'd0,  64'hFFFFFFFF_FFFFFFFF, 96'h0000_0000_0000_0000_0004_0002, 4};
        vecs[2] = '{8'h33, 4'd15, 64'h88776655_44332211, 96'h8877_6655_4433_2211_000C_0033, 12};
        vecs[3] = '{8'hA5, 4'd9,  64'h01020304_05060708, 96'h0102_0304_0506_0708_000C_00A5, 12};
        vecs[4] = '{8'h7E, 4'd1,  64'hFFFFFFFF_FFFFFF5A, 96'h0000_0000_0000_005A_0005_007E, 5};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            64'({busy_o, tx_valid_o, tx_data_o, echo_ready_o, res_ready_o}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Tie straight after reset: result first, then echo; a tie right after
        // the result frame goes to echo, and the held result follows.
        echo_data_i  = 8'h44;
        echo_last_i  = 1'b1;
        echo_valid_i = 1'b1;
        model_frame(8'h10, 4'd2, 64'h0000_0000_0000_BEEF);
        start_result(8'h10, 4'd2, 64'h0000_0000_0000_BEEF, 1'b1);
        res_opcode_i = 8'h20;
        res_len_i    = 4'd1;
        res_data_i   = 64'h77;
        tx_ready_i   = 1'b0;
        @(negedge clk);
        chk("echo_blocked", 64'({echo_ready_o, res_ready_o, busy_o}), 64'(3'b001));
        @(posedge clk); #1;
        drain(100, 16'h0, 1'b0, cyc);
        echo_packet(32'h44, 1, 100);
        model_frame(8'h20, 4'd1, 64'h77);
        start_result(8'h20, 4'd1, 64'h77, 1'b0);
        drain(100, 16'h0, 1'b0, cyc);
        check_idle();

        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < vecs[v].exp_n; k++) exp_q.push_back(vecs[v].exp_bytes[8*k +: 8]);
            start_result(vecs[v].op, vecs[v].len, vecs[v].data, 1'b0);
            drain(100, 16'h0, 1'b0, cyc);
            chk("vec_cycles", 64'(cyc), 64'(vecs[v].exp_n));
            check_idle();
        end

        echo_packet(32'h0033_2211, 3, 100);
        check_idle();

        // Backpressure pattern 1,0,0,1,1,...
        model_frame(8'hC3, 4'd3, 64'h0000_0000_00E3_E2E1);
        start_result(8'hC3, 4'd3, 64'h0000_0000_00E3_E2E1, 1'b0);
        drain(0, 16'hFFF9, 1'b1, cyc);
        chk("bp_cycles", 64'(cyc), 64'(9));
        check_idle();

        // Reset after two bytes of a frame.
        model_frame(8'h55, 4'd4, 64'h0000_0000_4433_2211);
        start_result(8'h55, 4'd4, 64'h0000_0000_4433_2211, 1'b0);
        tx_ready_i = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("pre_reset_byte", 64'({tx_valid_o, tx_data_o}), 64'({1'b1, exp_q.pop_front()}));
            @(posedge clk); #1;
        end
        exp_q.delete();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset", 64'({tx_valid_o, busy_o, tx_data_o}), 64'(0));
        @(posedge clk); #1;
        echo_packet(32'h00CC_BBAA, 3, 60);
        check_idle();

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(1) == 0) begin
                r_echo = $urandom;
                echo_packet(r_echo, int'($urandom_range(4, 1)), int'($urandom_range(100, 40)));
            end else begin
                r_op   = 8'($urandom);
                r_len  = 4'($urandom);
                r_data = {$urandom, $urandom};
                model_frame(r_op, r_len, r_data);
                start_result(r_op, r_len, r_data, 1'b0);
                drain(int'($urandom_range(100, 30)), 16'h0, 1'b0, cyc);
            end
            check_idle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
